// File: rtl/divisible_by_n_if.sv
// divisible_by_n_if -- serial bit stream in / divisibility result out.
//   master (stimulus side): drives x, x_valid, clear; samples y, rem, y_valid, seen
//   slave  (divisible_by_n): samples x, x_valid, clear; drives y, rem, y_valid, seen
//   x        serial data bit
//   x_valid  x is accepted on a rising edge where x_valid=1
//   clear    synchronous restart of the number under test
//   y        accepted stream is divisible by DIVISOR
//   rem      accepted stream mod DIVISOR (REM_W bits)
//   y_valid  one-cycle pulse after each accepted bit
//   seen     at least one bit accepted since reset/clear
interface divisible_by_n_if #(
  parameter int unsigned DIVISOR = 4
);
  localparam int unsigned REM_W = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR);

  logic             x;
  logic             x_valid;
  logic             clear;
  logic             y;
  logic [REM_W-1:0] rem;
  logic             y_valid;
  logic             seen;

  modport master (
    output x, x_valid, clear,
    input  y, rem, y_valid, seen
  );

  modport slave (
    input  x, x_valid, clear,
    output y, rem, y_valid, seen
  );
endinterface

// File: rtl/divisible_by_n.sv
// divisible_by_n -- serial divisibility tester.
// Tracks the remainder of an unbounded serial bit stream modulo DIVISOR using
// only shifts, adds and one conditional subtract per bit (no divider).
//   clk  : single clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : divisible_by_n_if.slave (x, x_valid, clear in; y, rem, y_valid, seen out)
// Configuration macro:
//   DIVISIBLE_BY_N_LSB_FIRST_EN  undefined -> bits arrive MSB-first (default)
//                                defined   -> bits arrive LSB-first; a weight
//                                             register p = 2^k mod DIVISOR is added
module divisible_by_n #(
  parameter int unsigned DIVISOR = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  divisible_by_n_if.slave        bus
);
  localparam int unsigned REM_W = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR);
  // DIVISOR always fits in REM_W+1 bits, including exact powers of two.
  localparam logic [REM_W:0] DIV_W = (REM_W+1)'(DIVISOR);

  logic [REM_W-1:0] r_q, r_d;
  logic             seen_q, seen_d;
  logic             y_valid_q, y_valid_d;
  logic             y_q, y_d;
  logic [REM_W:0]   t_s;
  logic [REM_W-1:0] r_next_s;
`ifdef DIVISIBLE_BY_N_LSB_FIRST_EN
  logic [REM_W-1:0] p_q, p_d;
  logic [REM_W:0]   p2_s;
  logic [REM_W-1:0] p_next_s;
`endif

`ifdef DIVISIBLE_BY_N_LSB_FIRST_EN
  // Remainder/weight update for one LSB-first bit: r += x*p, p *= 2, each mod DIVISOR.
  // Both sums are below 2*DIVISOR, so a single conditional subtract suffices.
  always_comb begin
    t_s  = {1'b0, r_q} + ({1'b0, p_q} & {(REM_W+1){bus.x}});
    p2_s = {p_q, 1'b0};
    if (t_s >= DIV_W) begin
      r_next_s = REM_W'(t_s - DIV_W);
    end else begin
      r_next_s = REM_W'(t_s);
    end
    if (p2_s >= DIV_W) begin
      p_next_s = REM_W'(p2_s - DIV_W);
    end else begin
      p_next_s = REM_W'(p2_s);
    end
  end
`else
  // Remainder update for one MSB-first bit: t = 2r + x, then one conditional subtract.
  always_comb begin
    t_s = {r_q, bus.x};
    if (t_s >= DIV_W) begin
      r_next_s = REM_W'(t_s - DIV_W);
    end else begin
      r_next_s = REM_W'(t_s);
    end
  end
`endif

  // Next-state selection: clear beats accept, idle cycles hold everything.
  always_comb begin
    r_d       = r_q;
    seen_d    = seen_q;
    y_valid_d = 1'b0;
`ifdef DIVISIBLE_BY_N_LSB_FIRST_EN
    p_d       = p_q;
`endif
    if (bus.clear) begin
      r_d       = '0;
      seen_d    = 1'b0;
      y_valid_d = 1'b0;
`ifdef DIVISIBLE_BY_N_LSB_FIRST_EN
      p_d       = REM_W'(1);
`endif
    end else if (bus.x_valid) begin
      r_d       = r_next_s;
      seen_d    = 1'b1;
      y_valid_d = 1'b1;
`ifdef DIVISIBLE_BY_N_LSB_FIRST_EN
      p_d       = p_next_s;
`endif
    end else begin
      r_d       = r_q;
      seen_d    = seen_q;
      y_valid_d = 1'b0;
    end
    // y is kept as its own flop so the output carries no logic after the register.
    y_d = seen_d & (r_d == '0);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      seen_q    <= 1'b0;
      y_valid_q <= 1'b0;
      y_q       <= 1'b0;
`ifdef DIVISIBLE_BY_N_LSB_FIRST_EN
      p_q       <= REM_W'(1);
`endif
    end else begin
      r_q       <= r_d;
      seen_q    <= seen_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
`ifdef DIVISIBLE_BY_N_LSB_FIRST_EN
      p_q       <= p_d;
`endif
    end
  end

  assign bus.rem     = r_q;
  assign bus.seen    = seen_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y       = y_q;
endmodule

// File: doc/divisible_by_n.md
DIVISIBLE_BY_N -- requirements
Module: divisible_by_n

Interface
REQ-001 The block SHALL have parameter DIVISOR, default 4: the modulus being tested; legal range 2..65535.
REQ-002 The block SHALL have derived localparam REM_W, equal to $clog2(DIVISOR) with a minimum of 1: the remainder width.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port x, input, width 1: serial data bit.
REQ-006 The block SHALL have port x_valid, input, width 1: x is accepted on a rising edge where x_valid=1.
REQ-007 The block SHALL have port clear, input, width 1: synchronous restart of the number being tested.
REQ-008 The block SHALL have port y, output, width 1: the accepted bit stream is divisible by DIVISOR.
REQ-009 The block SHALL have port rem, output, width REM_W: current remainder of the accepted stream mod DIVISOR.
REQ-010 The block SHALL have port y_valid, output, width 1: single-cycle pulse one cycle after each accepted bit.
REQ-011 The block SHALL have port seen, output, width 1: at least one bit has been accepted since reset or clear.

Function
REQ-012 The block SHALL hold remainder state r, always in the range 0..DIVISOR-1.
REQ-013 On an MSB-first accept, the block SHALL compute t = 2*r + x in REM_W+1 bits, then set r = t - DIVISOR if t >= DIVISOR, else r = t (no divider, no modulo operator).
REQ-014 rem SHALL equal r directly from the register (Moore; no combinational path from x).
REQ-015 y SHALL equal seen AND (r == 0), so y=0 before the first accepted bit.
REQ-016 seen SHALL be set on the first accepted bit and SHALL then hold until rst or clear.
REQ-017 y_valid SHALL be registered and SHALL equal 1 in the cycle after every accept, else 0; back-to-back accepts SHALL give a continuous high.
REQ-018 With x_valid=0 and clear=0, r, seen and y SHALL hold.
REQ-019 clear=1 SHALL set r=0, seen=0 and y_valid=0 on the next edge and SHALL override x_valid in the same cycle (that bit is dropped).
REQ-020 The stream length SHALL be unbounded; no counter saturates or wraps in MSB-first mode.

Reset
REQ-021 Asserting rst SHALL immediately set r=0, seen=0, y_valid=0, and therefore y=0 and rem=0, independent of clk.
REQ-022 rst asserted mid-stream SHALL discard all partial state; the first accept after release SHALL be treated as the MSB of a new number.
REQ-023 While rst=1, the block SHALL ignore x_valid and clear.

Configuration
REQ-024 The block SHALL support macro DIVISIBLE_BY_N_LSB_FIRST_EN.
REQ-025 With DIVISIBLE_BY_N_LSB_FIRST_EN undefined, the block SHALL operate MSB-first per REQ-013.
REQ-026 With DIVISIBLE_BY_N_LSB_FIRST_EN defined, bits SHALL arrive LSB-first and the block SHALL add a register p (weight 2^k mod DIVISOR), reset/clear value 1.
REQ-027 In LSB-first mode, each accept SHALL set r = (r + x*p) with one conditional subtract of DIVISOR, and p = (2*p) with one conditional subtract of DIVISOR.
REQ-028 In LSB-first mode, p SHALL reset to 1 on rst and on clear; p SHALL hold when nothing is accepted.
REQ-029 The port list SHALL be identical in both builds.

Verification
REQ-030 Scenario MSB-first: DIVISOR=4, after rst pulse, accept 1,0,0,1,1,0,1,0 on consecutive cycles -> rem = 1,2,0,1,3,2,1,2, y = 0,0,1,0,0,0,0,0, y_valid high for 8 cycles.
REQ-031 Scenario MSB-first, DIVISOR=3: accept 1,1,0 -> rem = 1,0,0 and y = 0,1,1; then x_valid=0 for 5 cycles -> rem=0, y=1, y_valid=0 throughout.
REQ-032 Scenario MSB-first, DIVISOR=5: accept 1,1,1,1 (value 15) -> final rem=0, y=1; then clear with x_valid=1, x=1 in the same cycle -> rem=0, seen=0, y=0, bit dropped.
REQ-033 Scenario MSB-first, DIVISOR=7: accept 1,1,0, assert rst asynchronously mid-cycle -> outputs 0 before the next edge; then accept 1,1,1 -> rem=0, y=1.
REQ-034 Scenario LSB-first macro, DIVISOR=3: accept 1,1,0,1 (value 11) -> rem = 1,0,0,2 and y = 0,1,1,0.
REQ-035 Scenario random: DIVISOR in {2,6,10,13}, 64-bit random streams with random x_valid gaps -> rem matches a reference model every cycle.
